output_channel_buffer: RTL and testbench
========================================

OUTPUT_CHANNEL_BUFFER -- requirements
Module: output_channel_buffer

Interface
REQ-001 Parameter: WIDTH, 64, packet width in bits.
REQ-002 Parameter: HOP_MSB, 55, MSB of 8-bit hop field (bits HOP_MSB:HOP_MSB-7).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
REQ-005 di  input  WIDTH  packet from crossbar, sampled when wi=1.
REQ-006 wi  input  1  write strobe from crossbar/arbiter (grant issued).
REQ-007 to_pe  input  1  qualifies di: 1 = packet leaves to local PE, hop not modified.
REQ-008 full  output  1  backpressure to arbiter; 1 = no free entry, arbiter shall not grant.
REQ-009 so  output  1  send-out valid to downstream input buffer.
REQ-010 ro  input  1  ready-out from downstream; transfer occurs when so=1 and ro=1.
REQ-011 dout  output  WIDTH  head packet presented downstream, valid while so=1.
REQ-012 hop_err  output  1  sticky: packet with hop=0 was routed to a neighbour port.
REQ-013 pkt_cnt  output  16  count of packets transferred downstream.

Function
REQ-014 Storage: 2-entry FIFO (head, tail), occupancy count 0..2, in-order delivery.
REQ-015 Write accepted on rising edge when wi=1 and full=0; wi=1 with full=1 shall be ignored (packet dropped, state unchanged).
REQ-016 On accept with to_pe=0 and hop!=0: stored hop = hop-1, all other bits stored unchanged.
REQ-017 On accept with to_pe=0 and hop=0: stored unmodified (no wrap to 8'hFF), hop_err set to 1.
REQ-018 On accept with to_pe=1: packet stored unmodified regardless of hop.
REQ-019 so = (count!=0); dout = head entry; dout = 0 when count=0.
REQ-020 so and dout derive from registered state only; no combinational path from di/wi/ro to so/dout.
REQ-021 Latency: packet accepted at edge N appears on dout with so=1 after edge N (1 cycle) when FIFO was empty.
REQ-022 Transfer (so=1, ro=1) at an edge pops head; next entry becomes head same edge.
REQ-023 full = (count==2), registered; simultaneous pop at count=2 does not permit same-cycle write.
REQ-024 Simultaneous accept and pop at count=1: count stays 1, new packet becomes head.
REQ-025 ro=0 with so=1: head and dout held stable until transfer.
REQ-026 ro ignored when so=0.
REQ-027 pkt_cnt increments by 1 per transfer, wraps 16'hFFFF -> 0.
REQ-028 hop_err cleared only by reset.

Reset
REQ-029 reset=0 asynchronously forces count=0, so=0, full=0, dout=0, hop_err=0, pkt_cnt=0, entries=0.
REQ-030 Reset asserted mid-transfer discards all stored packets; no transfer is counted for that cycle.
REQ-031 After reset release, first wi=1 edge is accepted normally.

Verification
REQ-032 Single packet: di=64'h00_03_...(hop=3), to_pe=0, wi=1 one cycle, ro=1 -> next cycle so=1, dout hop field=8'h02, then so=0, pkt_cnt=1.
REQ-033 Fill/backpressure: ro=0, three writes A,B,C on consecutive cycles -> full=1 after B, C dropped; ro=1 -> A then B delivered in order, full=0 after first pop.
REQ-034 Local PE: hop=0, to_pe=1 -> dout hop=0, hop_err=0; hop=0, to_pe=0 -> dout hop=0, hop_err=1 and stays 1.
REQ-035 Simultaneous: count=1 holding A, wi=1 (B) and ro=1 same edge -> count=1, dout=B.
REQ-036 Reset mid-operation: count=2, reset=0 between edges -> so=0, full=0, dout=0 immediately, pkt_cnt=0.
REQ-037 Counter wrap: 65536 transfers -> pkt_cnt returns to 0.

Source files
------------

// File: rtl/output_channel_buffer.sv
// ---------------------------------------------------------------------------
// output_channel_buffer
//
// Two-entry in-order output buffer sitting between a router crossbar and the
// downstream input buffer of the next hop (or the local PE). Packets routed to
// a neighbour have their hop field decremented on the way in. A packet that
// arrives with an exhausted hop count and is still headed for a neighbour
// is stored untouched and raises a sticky error flag.
//
// Parameters
//   WIDTH    packet width in bits
//   HOP_MSB  MSB of the 8-bit hop field (bits HOP_MSB:HOP_MSB-7)
//
// Ports
//   clk      clock, all state updates on the rising edge
//   reset    asynchronous active-low reset
//   di       packet from the crossbar, sampled when wi=1
//   wi       write strobe (grant issued)
//   to_pe    1 = packet goes to the local PE, hop field left alone
//   full     backpressure to the arbiter, both entries occupied
//   so       send-out valid to downstream
//   ro       ready-out from downstream
//   dout     head packet, zero when the buffer is empty
//   hop_err  sticky flag: hop=0 packet routed to a neighbour
//   pkt_cnt  wrapping count of packets transferred downstream
// ---------------------------------------------------------------------------
module output_channel_buffer #(
    parameter int WIDTH   = 64,
    parameter int HOP_MSB = 55
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] di,
    input  logic             wi,
    input  logic             to_pe,
    output logic             full,
    output logic             so,
    input  logic             ro,
    output logic [WIDTH-1:0] dout,
    output logic             hop_err,
    output logic [15:0]      pkt_cnt
);

    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] tail;
    logic [1:0]       count;

    logic [WIDTH-1:0] head_next;
    logic [WIDTH-1:0] tail_next;
    logic [1:0]       count_next;
    logic [WIDTH-1:0] wdata;
    logic [7:0]       hop_in;
    logic             accept;
    logic             pop;
    logic             hop_zero_fwd;

    // Outputs come straight from registered state so nothing from di/wi/ro
    // reaches so/dout/full combinationally.
    assign full = (count == 2'd2);
    assign so   = (count != 2'd0);
    assign dout = so ? head : '0;

    assign accept       = wi && !full;
    assign pop          = so && ro;
    assign hop_in       = di[HOP_MSB -: 8];
    assign hop_zero_fwd = accept && !to_pe && (hop_in == 8'd0);

    // Hop decrement for neighbour-bound packets; a zero hop is kept as zero
    // rather than wrapping to 8'hFF.
    always_comb begin
        wdata = di;
        if (!to_pe && (hop_in != 8'd0)) begin
            wdata[HOP_MSB -: 8] = hop_in - 8'd1;
        end
    end

    // FIFO bookkeeping. A pop at count=2 shifts tail into head; a write at
    // count=1 together with a pop lands the new packet directly in head.
    always_comb begin
        head_next  = head;
        tail_next  = tail;
        count_next = count;
        case (count)
            2'd0: begin
                if (accept) begin
                    head_next  = wdata;
                    count_next = 2'd1;
                end
            end
            2'd1: begin
                if (accept && pop) begin
                    head_next = wdata;
                end else if (accept) begin
                    tail_next  = wdata;
                    count_next = 2'd2;
                end else if (pop) begin
                    count_next = 2'd0;
                end
            end
            default: begin
                if (pop) begin
                    head_next  = tail;
                    count_next = 2'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head    <= '0;
            tail    <= '0;
            count   <= 2'd0;
            hop_err <= 1'b0;
            pkt_cnt <= 16'd0;
        end else begin
            head  <= head_next;
            tail  <= tail_next;
            count <= count_next;
            if (hop_zero_fwd) begin
                hop_err <= 1'b1;
            end
            if (pop) begin
                pkt_cnt <= pkt_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_output_channel_buffer.sv
// ---------------------------------------------------------------------------
// Directed testbench for output_channel_buffer. Inputs change 2ns after a
// rising edge and outputs are checked there as well, away from the edge.
// ---------------------------------------------------------------------------
module tb_output_channel_buffer;

    logic        clk;
    logic        reset;
    logic [63:0] di;
    logic        wi;
    logic        to_pe;
    logic        full;
    logic        so;
    logic        ro;
    logic [63:0] dout;
    logic        hop_err;
    logic [15:0] pkt_cnt;

    int vec_count;
    int err_count;

    output_channel_buffer #(.WIDTH(64), .HOP_MSB(55)) dut (
        .clk     (clk),
        .reset   (reset),
        .di      (di),
        .wi      (wi),
        .to_pe   (to_pe),
        .full    (full),
        .so      (so),
        .ro      (ro),
        .dout    (dout),
        .hop_err (hop_err),
        .pkt_cnt (pkt_cnt)
    );

    // 10ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs, let the edge happen, then idle the strobes.
    task automatic applyStimulus(input logic w, input logic [63:0] d,
                                 input logic tp, input logic r);
        wi    = w;
        di    = d;
        to_pe = tp;
        ro    = r;
        @(posedge clk);
        #2;
        wi = 1'b0;
        ro = 1'b0;
    endtask

    // Single comparison point for every check in the bench.
    task automatic checkOutput(input string tag, input logic [63:0] obs,
                               input logic [63:0] exp);
        vec_count++;
        if (obs !== exp) begin
            err_count++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        vec_count = 0;
        err_count = 0;
        wi    = 1'b0;
        ro    = 1'b0;
        to_pe = 1'b0;
        di    = '0;
        reset = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #2;
        checkOutput("rst_so",      {63'd0, so},      64'd0);
        checkOutput("rst_full",    {63'd0, full},    64'd0);
        checkOutput("rst_dout",    dout,             64'd0);
        checkOutput("rst_hop_err", {63'd0, hop_err}, 64'd0);
        checkOutput("rst_pkt_cnt", {48'd0, pkt_cnt}, 64'd0);
        reset = 1'b1;
        #3;

        // Single packet, hop 3 -> 2; ro=1 while empty must be ignored
        applyStimulus(1'b1, 64'h0003_1111_2222_3333, 1'b0, 1'b1);
        checkOutput("single_so",   {63'd0, so},      64'd1);
        checkOutput("single_dout", dout,             64'h0002_1111_2222_3333);
        checkOutput("single_cnt0", {48'd0, pkt_cnt}, 64'd0);
        applyStimulus(1'b0, 64'd0, 1'b0, 1'b1);
        checkOutput("single_so_after", {63'd0, so},  64'd0);
        checkOutput("single_dout_after", dout,       64'd0);
        checkOutput("single_cnt1", {48'd0, pkt_cnt}, 64'd1);

        // Fill / backpressure: A,B,C with ro=0, C dropped
        applyStimulus(1'b1, 64'h0010_AAAA_0000_0001, 1'b0, 1'b0);
        checkOutput("fill_full_a", {63'd0, full}, 64'd0);
        applyStimulus(1'b1, 64'h0020_BBBB_0000_0002, 1'b0, 1'b0);
        checkOutput("fill_full_b", {63'd0, full}, 64'd1);
        checkOutput("fill_dout_b", dout,          64'h000F_AAAA_0000_0001);
        applyStimulus(1'b1, 64'h0030_CCCC_0000_0003, 1'b0, 1'b0);
        checkOutput("fill_full_c", {63'd0, full}, 64'd1);
        checkOutput("fill_dout_c", dout,          64'h000F_AAAA_0000_0001);
        applyStimulus(1'b0, 64'd0, 1'b0, 1'b0);
        checkOutput("hold_dout",   dout,          64'h000F_AAAA_0000_0001);
        applyStimulus(1'b0, 64'd0, 1'b0, 1'b1);
        checkOutput("pop1_dout",   dout,             64'h001F_BBBB_0000_0002);
        checkOutput("pop1_full",   {63'd0, full},    64'd0);
        checkOutput("pop1_cnt",    {48'd0, pkt_cnt}, 64'd2);
        applyStimulus(1'b0, 64'd0, 1'b0, 1'b1);
        checkOutput("pop2_so",     {63'd0, so},      64'd0);
        checkOutput("pop2_cnt",    {48'd0, pkt_cnt}, 64'd3);

        // Local PE with hop 0: untouched, no error
        applyStimulus(1'b1, 64'hFF00_1234_5678_9ABC, 1'b1, 1'b0);
        checkOutput("pe_hop0_dout", dout,             64'hFF00_1234_5678_9ABC);
        checkOutput("pe_hop0_err",  {63'd0, hop_err}, 64'd0);
        applyStimulus(1'b0, 64'd0, 1'b0, 1'b1);
        // Local PE with nonzero hop: untouched
        applyStimulus(1'b1, 64'h0007_0000_0000_0077, 1'b1, 1'b0);
        checkOutput("pe_hop7_dout", dout,             64'h0007_0000_0000_0077);
        applyStimulus(1'b0, 64'd0, 1'b0, 1'b1);
        // Neighbour with hop 0: no wrap, sticky error
        applyStimulus(1'b1, 64'h1200_0000_0000_0055, 1'b0, 1'b0);
        checkOutput("nb_hop0_dout", dout,             64'h1200_0000_0000_0055);
        checkOutput("nb_hop0_err",  {63'd0, hop_err}, 64'd1);
        applyStimulus(1'b0, 64'd0, 1'b0, 1'b1);
        checkOutput("err_sticky",   {63'd0, hop_err}, 64'd1);
        checkOutput("pe_cnt",       {48'd0, pkt_cnt}, 64'd6);

        // Simultaneous write and pop at count=1
        applyStimulus(1'b1, 64'h0005_0000_0000_00A1, 1'b0, 1'b0);
        applyStimulus(1'b1, 64'h0009_0000_0000_00B2, 1'b0, 1'b1);
        checkOutput("sim_dout", dout,             64'h0008_0000_0000_00B2);
        checkOutput("sim_full", {63'd0, full},    64'd0);
        checkOutput("sim_cnt",  {48'd0, pkt_cnt}, 64'd7);
        applyStimulus(1'b0, 64'd0, 1'b0, 1'b1);
        checkOutput("sim_empty", {63'd0, so},     64'd0);
        checkOutput("sim_cnt2", {48'd0, pkt_cnt}, 64'd8);

        // Reset mid-operation with two entries and ro pending
        applyStimulus(1'b1, 64'h0001_0000_0000_0001, 1'b1, 1'b0);
        applyStimulus(1'b1, 64'h0002_0000_0000_0002, 1'b1, 1'b0);
        checkOutput("pre_rst_full", {63'd0, full}, 64'd1);
        ro = 1'b1;
        #1;
        reset = 1'b0;
        #1;
        checkOutput("mid_rst_so",   {63'd0, so},      64'd0);
        checkOutput("mid_rst_full", {63'd0, full},    64'd0);
        checkOutput("mid_rst_dout", dout,             64'd0);
        checkOutput("mid_rst_cnt",  {48'd0, pkt_cnt}, 64'd0);
        checkOutput("mid_rst_err",  {63'd0, hop_err}, 64'd0);
        @(posedge clk);
        #2;
        checkOutput("rst_hold_cnt", {48'd0, pkt_cnt}, 64'd0);
        ro    = 1'b0;
        reset = 1'b1;
        #1;
        applyStimulus(1'b1, 64'h0004_0000_0000_00C3, 1'b0, 1'b0);
        checkOutput("post_rst_so",   {63'd0, so}, 64'd1);
        checkOutput("post_rst_dout", dout,        64'h0003_0000_0000_00C3);
        applyStimulus(1'b0, 64'd0, 1'b0, 1'b1);
        checkOutput("post_rst_cnt", {48'd0, pkt_cnt}, 64'd1);

        // Counter wrap: one transfer per cycle via write+pop at count=1
        applyStimulus(1'b1, 64'h0000_0000_0000_0F0F, 1'b1, 1'b0);
        wi    = 1'b1;
        ro    = 1'b1;
        to_pe = 1'b1;
        repeat (65534) @(posedge clk);
        #2;
        checkOutput("wrap_pre", {48'd0, pkt_cnt}, 64'hFFFF);
        wi = 1'b0;
        @(posedge clk);
        #2;
        checkOutput("wrap_zero", {48'd0, pkt_cnt}, 64'd0);
        checkOutput("wrap_empty", {63'd0, so},     64'd0);
        ro = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
        $finish;
    end

endmodule
